// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   rx_state_t  - receive FSM state encodings
//   vote_*      - oversample positions of the three majority-vote samples
//   parity_calc - data parity helper, also used by the TX serializer
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Widest word parity_calc accepts; narrower words are zero-extended.
  localparam int unsigned PARITY_MAX_WIDTH = 32;

  // First vote sample, one tick before the bit centre.
  function automatic int unsigned vote_first(input int unsigned oversample);
    return (oversample / 32'd2) - 32'd1;
  endfunction

  // Middle vote sample, at the bit centre.
  function automatic int unsigned vote_mid(input int unsigned oversample);
    return oversample / 32'd2;
  endfunction

  // Last vote sample; the bit decision is taken on this tick.
  function automatic int unsigned vote_last(input int unsigned oversample);
    return (oversample / 32'd2) + 32'd1;
  endfunction

  // Expected parity bit: XOR of the data, inverted for odd parity.
  function automatic logic parity_calc(input logic [PARITY_MAX_WIDTH-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchronizer, sample-tick prescaler, oversample
// counter and 3-sample majority vote for the UART receiver.
// Ports:
//   sys_clk, rst  - clock, synchronous active-high reset
//   rxd_i         - asynchronous serial line (idles high)
//   run           - high while a frame is in progress; low holds the
//                   prescaler and oversample counter at 0
//   line          - synchronized serial line
//   tick          - one-cycle sample tick
//   s             - oversample position within the current bit
//   vote          - majority of the three samples around the bit centre
//   vote_valid    - vote is meaningful this cycle (decision tick)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_DIV    = 27,
  localparam int unsigned SW = $clog2(OVERSAMPLE),
  localparam int unsigned PW = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          rxd_i,
  input  logic          run,
  output logic          line,
  output logic          tick,
  output logic [SW-1:0] s,
  output logic          vote,
  output logic          vote_valid
);

  localparam logic [SW-1:0] S_V0   = SW'(vote_first(OVERSAMPLE));
  localparam logic [SW-1:0] S_V1   = SW'(vote_mid(OVERSAMPLE));
  localparam logic [SW-1:0] S_V2   = SW'(vote_last(OVERSAMPLE));
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 32'd1);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 32'd1);

  logic          sync1;
  logic          sync2;
  logic [PW-1:0] presc;
  logic          samp_a;
  logic          samp_b;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd_i;
      sync2 <= sync1;
    end
  end

  // Sample-tick prescaler, held at 0 while no frame is in progress.
  always_ff @(posedge sys_clk) begin
    if (rst || !run) begin
      presc <= '0;
    end else if (presc == P_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Oversample position counter, wrapping every bit period.
  always_ff @(posedge sys_clk) begin
    if (rst || !run) begin
      s <= '0;
    end else if (tick) begin
      s <= (s == S_LAST) ? '0 : s + SW'(1);
    end else begin
      s <= s;
    end
  end

  // Capture the first two vote samples; the third is the live line.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (tick && (s == S_V0)) samp_a <= line;
      if (tick && (s == S_V1)) samp_b <= line;
    end
  end

  // Tick, majority vote and decision strobe.
  always_comb begin
    line       = sync2;
    tick       = run && (presc == P_LAST);
    vote       = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
    vote_valid = tick && (s == S_V2);
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART serial receive front end. Detects and
// validates the start bit, reassembles LSB-first data words, checks
// optional parity and the stop bit, and presents each word on a
// valid/ready port.
// Ports:
//   sys_clk, rst   - clock, synchronous active-high reset
//   rxd_i          - asynchronous serial line (idles high)
//   dout_o         - received word
//   dout_valid_o   - dout_o holds an unconsumed word
//   dout_ready_i   - consumer accepts the held word
//   parity_err_o   - parity mismatch for the held word
//   frame_err_o    - stop bit sampled low for the held word
//   overrun_o      - one-cycle pulse when a finished word is dropped
//   busy_o         - a frame is in progress
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rxd_i,
  output logic [WORD_SIZE-1:0] dout_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (WORD_SIZE > 32'd1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 32'd1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 32'd1);

  rx_state_t                     state;
  logic [BW-1:0]                 bit_idx;
  logic [WORD_SIZE-1:0]          shreg;
  logic                          par_err;
  logic                          run;
  logic                          line;
  logic                          tick;
  logic [SW-1:0]                 s;
  logic                          vote;
  logic                          vote_valid;
  logic                          bit_end;
  logic [PARITY_MAX_WIDTH-1:0]   word_ext;
  logic                          exp_par;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CLK_DIV    (CLK_DIV)
  ) u_sampler (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .rxd_i      (rxd_i),
    .run        (run),
    .line       (line),
    .tick       (tick),
    .s          (s),
    .vote       (vote),
    .vote_valid (vote_valid)
  );

  // Frame-progress qualifiers and the expected parity of the assembled word.
  always_comb begin
    run                      = (state != ST_IDLE);
    bit_end                  = tick && (s == S_LAST);
    word_ext                 = '0;
    word_ext[WORD_SIZE-1:0]  = shreg;
    exp_par                  = parity_calc(word_ext, (PARITY_ODD != 32'd0));
  end

  // Receive FSM with the output word register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      busy_o       <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      // Consumed word; a word loading in the STOP branch below overrides this.
      if (dout_valid_o && dout_ready_i) dout_valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!line) begin
            state   <= ST_START;
            busy_o  <= 1'b1;
            bit_idx <= '0;
            par_err <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that votes high was a glitch: drop back silently.
          if (vote_valid && vote) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_valid) shreg[bit_idx] <= vote;
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 32'd0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (vote_valid) par_err <= (vote != exp_par);
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave on the stop decision, not the bit end, so a back-to-back
          // start edge is caught in IDLE.
          if (vote_valid) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            if (!dout_valid_o || dout_ready_i) begin
              dout_o       <= shreg;
              parity_err_o <= par_err;
              frame_err_o  <= ~vote;
              dout_valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

  localparam int CLK_DIV = 4;
  localparam int OS      = 16;
  localparam int BIT_CYC = CLK_DIV * OS;
  localparam int GAP     = 100;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       rxd_a   = 1'b1;
  logic       rxd_b   = 1'b1;
  logic       ready   = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, ovr_a, ovr_b, busy_a, busy_b;

  uart_rx_deserializer #(
    .WORD_SIZE(8), .OVERSAMPLE(OS), .CLK_DIV(CLK_DIV), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut_a (
    .sys_clk(sys_clk), .rst(rst), .rxd_i(rxd_a), .dout_o(dout_a), .dout_valid_o(valid_a),
    .dout_ready_i(ready), .parity_err_o(pe_a), .frame_err_o(fe_a), .overrun_o(ovr_a),
    .busy_o(busy_a)
  );

  uart_rx_deserializer #(
    .WORD_SIZE(8), .OVERSAMPLE(OS), .CLK_DIV(CLK_DIV), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_b (
    .sys_clk(sys_clk), .rst(rst), .rxd_i(rxd_b), .dout_o(dout_b), .dout_valid_o(valid_b),
    .dout_ready_i(ready), .parity_err_o(pe_b), .frame_err_o(fe_b), .overrun_o(ovr_b),
    .busy_o(busy_b)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] word;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t act_a[$], exp_a[$], act_b[$], exp_b[$];
  int   ovr_q[$];
  int   checks = 0;
  int   errors = 0;

  // Record every word handed over (valid && ready) and every overrun pulse.
  always @(negedge sys_clk) begin
    if (valid_a && ready) act_a.push_back(rec_t'{cyc, dout_a, pe_a, fe_a});
    if (valid_b && ready) act_b.push_back(rec_t'{cyc, dout_b, pe_b, fe_b});
    if (ovr_a) ovr_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timing: the line change at cycle t0 is seen synced at D=t0+2;
  // frame tick t falls at D+(t+1)*CLK_DIV; bit b is decided on tick
  // b*OS+OS/2+1; the word is valid one cycle after that decision.
  function automatic int accept_cycle(input int t0, input int stop_bit);
    return t0 + 2 + (stop_bit * OS + OS / 2 + 1 + 1) * CLK_DIV + 1;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    drive(sel, v);
    repeat (BIT_CYC) @(posedge sys_clk);
    #1;
  endtask

  // Caller is 1 time unit after a clock edge; the frame starts immediately.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_on,
                            input logic pbit, input logic stop);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
    if (par_on) hold_bit(sel, pbit);
    hold_bit(sel, stop);
    drive(sel, 1'b1);
    repeat (GAP) @(posedge sys_clk);
    #1;
  endtask

  task automatic compare(input bit sel, input string tag);
    rec_t a, e;
    int   na, ne;
    na = sel ? act_b.size() : act_a.size();
    ne = sel ? exp_b.size() : exp_a.size();
    check({tag, "_count"}, na, ne);
    for (int i = 0; i < ne && i < na; i++) begin
      a = sel ? act_b[i] : act_a[i];
      e = sel ? exp_b[i] : exp_a[i];
      check({tag, "_cycle"}, a.cyc, e.cyc);
      check({tag, "_word"}, {24'd0, a.word}, {24'd0, e.word});
      check({tag, "_perr"}, {31'd0, a.pe}, {31'd0, e.pe});
      check({tag, "_ferr"}, {31'd0, a.fe}, {31'd0, e.fe});
    end
    if (sel) begin act_b.delete(); exp_b.delete(); end
    else     begin act_a.delete(); exp_a.delete(); end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},  {24'd0, dout_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_perr"},  {31'd0, pe_a}, 32'd0);
    check({tag, "_ferr"},  {31'd0, fe_a}, 32'd0);
    check({tag, "_ovr"},   {31'd0, ovr_a}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    int         t0, t1, t2, lat;
    logic [7:0] d;
    logic       st, pb;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;

    // 0xA5, ready high: exact latency, busy/valid handover, one-cycle valid.
    t0  = cyc;
    lat = accept_cycle(t0, 9) - t0;
    exp_a.push_back(rec_t'{accept_cycle(t0, 9), 8'hA5, 1'b0, 1'b0});
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(posedge sys_clk);
        #1;
        check("a5_busy_before", {31'd0, busy_a}, 32'd1);
        check("a5_valid_before", {31'd0, valid_a}, 32'd0);
        @(posedge sys_clk);
        #1;
        check("a5_busy_at_valid", {31'd0, busy_a}, 32'd0);
        check("a5_valid_rise", {31'd0, valid_a}, 32'd1);
        @(posedge sys_clk);
        #1;
        check("a5_valid_fall", {31'd0, valid_a}, 32'd0);
      end
    join
    compare(1'b0, "a5");

    // Random words, occasionally with a low stop bit.
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      t0 = cyc;
      exp_a.push_back(rec_t'{accept_cycle(t0, 9), d, 1'b0, ~st});
      send_frame(1'b0, d, 1'b0, 1'b0, st);
    end
    compare(1'b0, "rand");

    // Stop bit low.
    t0 = cyc;
    exp_a.push_back(rec_t'{accept_cycle(t0, 9), 8'h3C, 1'b0, 1'b1});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    compare(1'b0, "frame_err");

    // 20-cycle glitch: START entered, start vote high, back to IDLE, no word.
    t0 = cyc;
    rxd_a = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("glitch_busy_start", {31'd0, busy_a}, 32'd1);
    repeat (17) @(posedge sys_clk);
    #1;
    rxd_a = 1'b1;
    repeat (24) @(posedge sys_clk);
    #1;
    check("glitch_busy_idle", {31'd0, busy_a}, 32'd0);
    repeat (GAP) @(posedge sys_clk);
    #1;
    compare(1'b0, "glitch");

    // Parity-enabled instance, even parity.
    t0 = cyc;
    exp_b.push_back(rec_t'{accept_cycle(t0, 10), 8'h07, 1'b1, 1'b0});
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    t0 = cyc;
    exp_b.push_back(rec_t'{accept_cycle(t0, 10), 8'h07, 1'b0, 1'b0});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      t0 = cyc;
      // Even parity: the count of ones over data plus parity bit must be even.
      exp_b.push_back(rec_t'{accept_cycle(t0, 10), d, ($countones({d, pb}) % 2) == 1, 1'b0});
      send_frame(1'b1, d, 1'b1, pb, 1'b1);
    end
    compare(1'b1, "parity");

    // Overrun: ready low, 0x11 held, 0x22 dropped with one pulse.
    ready = 1'b0;
    t1 = cyc;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    t2 = cyc;
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_held_word", {24'd0, dout_a}, 32'h11);
    check("ovr_held_valid", {31'd0, valid_a}, 32'd1);
    // Ready rises exactly in the stop-decision cycle of 0x33: 0x11 is taken
    // in that cycle and 0x33 loads, without an overrun.
    t0  = cyc;
    lat = accept_cycle(t0, 9) - t0;
    exp_a.push_back(rec_t'{accept_cycle(t0, 9) - 1, 8'h11, 1'b0, 1'b0});
    exp_a.push_back(rec_t'{accept_cycle(t0, 9), 8'h33, 1'b0, 1'b0});
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(posedge sys_clk);
        #1;
        ready = 1'b1;
      end
    join
    compare(1'b0, "ovr");
    check("ovr_pulse_count", ovr_q.size(), 32'd1);
    if (ovr_q.size() > 0) check("ovr_pulse_cycle", ovr_q[0], accept_cycle(t2, 9));
    ovr_q.delete();

    // Reset during data bit 4 with a word held; then a clean frame.
    ready = 1'b0;
    send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
    check("rst_pre_word", {24'd0, dout_a}, 32'h96);
    t0 = cyc;
    fork
      send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (349) @(posedge sys_clk);
        #1;
        check("rst_pre_busy", {31'd0, busy_a}, 32'd1);
        @(posedge sys_clk);
        #1;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
      end
    join
    ready = 1'b1;
    t0 = cyc;
    exp_a.push_back(rec_t'{accept_cycle(t0, 9), 8'h5A, 1'b0, 1'b0});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    compare(1'b0, "post_rst");
    check("final_ovr_count", ovr_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
